// File: rtl/x83_pkg.sv
// x83_pkg: shared constants, state type and the x83 constant-multiply helper
// for the x83 multiplier-sharing controller.
//   DW / OW   : default operand / product widths
//   K         : the constant being multiplied by (83 = 1 + 2 + 16 + 64)
//   SHIFTS    : shift set whose shifted copies sum to K
//   x83_mul() : shift-add product in OW bits (operand zero-extended by caller)
package x83_pkg;

  localparam int unsigned DW      = 16;
  localparam int unsigned OW      = 24;
  localparam int unsigned K       = 83;
  localparam int unsigned N_SHIFT = 4;
  localparam int unsigned SHIFTS [N_SHIFT] = '{0, 1, 4, 6};

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } x83_state_e;

  // d*83 as d + d<<1 + d<<4 + d<<6, wrapping in OW bits
  function automatic logic [OW-1:0] x83_mul(input logic [OW-1:0] d);
    logic [OW-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < N_SHIFT; i++) begin
      acc = acc + (d << SHIFTS[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/x83_rr_arb.sv
// x83_rr_arb: combinational round-robin priority picker.
//   i_req [N_REQ] : request vector
//   i_ptr [IDW]   : highest-priority index; search runs upward and wraps
//   i_en          : when low, nothing is granted
//   o_gnt [N_REQ] : one-hot grant (zero when nothing granted)
//   o_idx [IDW]   : encoded index of the grant (0 when nothing granted)
//   o_any         : a grant was made
module x83_rr_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

  logic [IDW-1:0] w_j;

  // First requester at or after i_ptr, modulo N_REQ
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    if (i_en) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        w_j = IDW'((32'(i_ptr) + k) % N_REQ);
        if (!o_any && i_req[w_j]) begin
          o_any      = 1'b1;
          o_gnt[w_j] = 1'b1;
          o_idx      = w_j;
        end
      end
    end
  end

endmodule

// File: rtl/x83_share_ctrl.sv
// x83_share_ctrl: round-robin sharing of one x83 constant multiplier among
// N_REQ valid/ready requesters, with a single registered output slot.
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid [N_REQ]      : per-requester operand valid
//   req_data  [N_REQ*DW]   : packed operands, requester i at [i*DW +: DW]
//   req_ready [N_REQ]      : combinational one-hot acceptance
//   out_valid/out_data/out_id/out_ready : registered result channel
// Optional build macro X83_STATS_EN adds stat_clr (in) and stat_cnt[15:0]
// (out), a saturating count of completed output handshakes.
module x83_share_ctrl
  import x83_pkg::x83_state_e, x83_pkg::EMPTY, x83_pkg::FULL, x83_pkg::x83_mul;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = x83_pkg::DW,
  parameter int unsigned OW    = x83_pkg::OW,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                out_valid,
  output logic [OW-1:0]       out_data,
  output logic [IDW-1:0]      out_id,
`ifdef X83_STATS_EN
  input  logic                stat_clr,
  output logic [15:0]         stat_cnt,
`endif
  input  logic                out_ready
);

  localparam int unsigned MW = x83_pkg::OW;

  x83_state_e       r_state;
  x83_state_e       w_state_nxt;
  logic [OW-1:0]    r_out_data;
  logic [IDW-1:0]   r_out_id;
  logic [IDW-1:0]   r_ptr;
  logic             w_slot_free;
  logic [N_REQ-1:0] w_gnt;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic [DW-1:0]    w_operand;
  logic [OW-1:0]    w_prod;

  // Slot is free when empty or being drained this cycle
  assign w_slot_free = (r_state == EMPTY) | (out_ready & out_valid);

  x83_rr_arb #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_slot_free),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign req_ready = w_gnt;

  // Operand of the granted requester through the shared multiplier
  assign w_operand = req_data[32'(w_idx) * DW +: DW];
  assign w_prod    = OW'(x83_mul(MW'(w_operand)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state: a grant always fills the slot; a drain without grant empties it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_any) w_state_nxt = FULL;
      FULL:    if (out_ready) w_state_nxt = w_any ? FULL : EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Result register and round-robin pointer, updated only on a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_id   <= '0;
      r_ptr      <= '0;
    end else if (w_any) begin
      r_out_data <= w_prod;
      r_out_id   <= w_idx;
      r_ptr      <= (32'(w_idx) == N_REQ - 1) ? '0 : w_idx + IDW'(1);
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

`ifdef X83_STATS_EN
  logic [15:0] r_stat_cnt;

  // Saturating handshake counter; clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_stat_cnt <= '0;
    else if (stat_clr)                            r_stat_cnt <= '0;
    else if (out_valid && out_ready && (r_stat_cnt != 16'hFFFF))
                                                  r_stat_cnt <= r_stat_cnt + 16'd1;
  end

  assign stat_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_x83_share_ctrl.sv
// tb_x83_share_ctrl: directed bench for x83_share_ctrl (N_REQ=4, DW=16, OW=24)
// with a behavioural reference model checked every negative clock edge.
// Stats checks are active when X83_STATS_EN is defined.
module tb_x83_share_ctrl;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic [1:0]  out_id;
  logic        out_ready;
`ifdef X83_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  x83_share_ctrl #(.N_REQ(4), .DW(16), .OW(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
`ifdef X83_STATS_EN
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit        m_valid;
  int        m_data;
  int        m_id;
  int        m_ptr;
  int        m_stat;

  function automatic int pick();
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    logic [3:0] r;
    g = pick();
    r = 4'b0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int opnd(input int i);
    logic [15:0] d;
    d = req_data[i*16 +: 16];
    return int'(d);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_data = 0; m_id = 0; m_ptr = 0; m_stat = 0;
    end else begin
      int g;
      bit hs;
      hs = m_valid && out_ready;
      g  = pick();
`ifdef X83_STATS_EN
      if (stat_clr)                   m_stat = 0;
      else if (hs && m_stat < 65535)  m_stat = m_stat + 1;
`endif
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = opnd(g) * 83;
        m_id    = g;
        m_ptr   = (g + 1) % N;
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare + upstream stability ----------------
  logic [3:0]  s_valid, s_ready;
  logic [63:0] s_data;
  bit          s_have = 1'b0;

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(exp_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_id",   32'(out_id),   32'(m_id));
    end
`ifdef X83_STATS_EN
    chk("stat_cnt", 32'(stat_cnt), 32'(m_stat));
`endif
    if (s_have) begin
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && !s_ready[i] && req_valid[i] &&
            (req_data[i*16 +: 16] !== s_data[i*16 +: 16])) begin
          failures++;
          $display("FAIL upstream_stable req%0d: data changed while waiting", i);
        end
      end
    end
    s_valid = req_valid;
    s_ready = req_ready;
    s_data  = req_data;
    s_have  = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_d(input int i, input logic [15:0] v);
    req_data[i*16 +: 16] = v;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0;
    req_data  = 64'b0;
    out_ready = 1'b0;
`ifdef X83_STATS_EN
    stat_clr  = 1'b0;
`endif
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_id",    32'(out_id),    32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // single requester 2, data 100
    set_d(2, 16'd100);
    req_valid = 4'b0100;
    out_ready = 1'b1;
    #1 chk("t1_ready", 32'(req_ready), 32'h4);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data",  32'(out_data),  32'h206C);
    chk("t1_id",    32'(out_id),    32'd2);

    // pointer now 3: 3 first, then wrap to 0
    set_d(3, 16'd1);
    set_d(0, 16'hFFFF);
    req_valid = 4'b1001;
    #1 chk("wrap_ready3", 32'(req_ready), 32'h8);
    tick();
    chk("wrap_id3",   32'(out_id),   32'd3);
    chk("wrap_data1", 32'(out_data), 32'd83);
    req_valid = 4'b0001;
    #1 chk("wrap_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("wrap_id0",    32'(out_id),   32'd0);
    chk("data_ffff",   32'(out_data), 32'h52FFAD);
    set_d(0, 16'd0);
    tick();
    chk("data_zero",   32'(out_data), 32'd0);
    req_valid = 4'b0;
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // all four valid: pointer at 1, grants 1,2,3,0,1,2,3,0 back to back
    for (int i = 0; i < N; i++) set_d(i, 16'(1000 * i + 7));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("burst_valid", 32'(out_valid), 32'd1);
      chk("burst_id",    32'(out_id),    32'((1 + k) % N));
    end

    // downstream stall for 5 cycles
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_id",    32'(out_id),    32'd0);
      chk("stall_data",  32'(out_data),  32'd581);
    end
    out_ready = 1'b1;
    #1 chk("release_ready", 32'(req_ready), 32'h2);
    tick();
    chk("release_id",   32'(out_id),   32'd1);
    chk("release_data", 32'(out_data), 32'd83581);

    // asynchronous reset while FULL
    req_valid = 4'b0;
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_id",    32'(out_id),    32'd0);
    tick();
    rst_n = 1'b1;

    // lowest valid index wins after reset; then three handshakes
    out_ready = 1'b1;
    set_d(1, 16'd5);
    set_d(2, 16'd6);
    req_valid = 4'b0110;
    #1 chk("post_rst_ready", 32'(req_ready), 32'h2);
    tick();
    chk("post_rst_id",   32'(out_id),   32'd1);
    chk("post_rst_data", 32'(out_data), 32'd415);
    req_valid = 4'b0100;
    tick();
    chk("post_rst_id2",   32'(out_id),   32'd2);
    chk("post_rst_data2", 32'(out_data), 32'd498);
    req_valid = 4'b0;
    tick();
    chk("post_rst_empty", 32'(out_valid), 32'd0);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0;
    tick();
`ifdef X83_STATS_EN
    chk("stat_three", 32'(stat_cnt), 32'd3);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr", 32'(stat_cnt), 32'd0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
